ps2_kbd_ctrl: RTL and testbench

Scan-code sequencer for the PS/2 receive path. It pops bytes from the `ps2_keyboard` FIFO through its `ready`/`read_n` handshake and folds the `E0` (extended) and `F0` (break) prefixes into single key events. It tracks the currently held key to flag typematic repeats and presents each event to a downstream consumer through a valid/ready handshake. It sits between `ps2_keyboard` and the display/ASCII logic in the top level.

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_kbd_ctrl.sv | 125 ++++++++++++
 tb/tb_ps2_kbd_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EMIT   = 2'd2
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_kbd_ctrl.sv
// Pops scan-code bytes from the keyboard FIFO, folds E0/F0 prefixes into key
// events, flags typematic repeats of the held key and hands events downstream.
//
//   state  | meaning
//   IDLE   | waiting for a FIFO byte; ages any pending prefix
//   DECODE | classify byte_r as prefix or key code, update held key
//   EMIT   | event presented on evt_*, waiting for evt_ready
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int PREFIX_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kbd_ready,
  input  logic [7:0] kbd_data,
  input  logic       kbd_overflow,
  output logic       kbd_read_n,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       evt_repeat,
  output logic [7:0] press_count,
  output logic       err_overflow,
  output logic       err_timeout
);

  localparam int CW = (PREFIX_TIMEOUT > 2) ? $clog2(PREFIX_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(PREFIX_TIMEOUT - 1);

  ps2_state_e    state;
  logic [7:0]    byte_r;
  logic          ext_pend;
  logic          brk_pend;
  logic          held_valid;
  logic [7:0]    held_code;
  logic          held_ext;
  logic [CW-1:0] to_cnt;
  logic          held_match;

  // Gated by rst_n so no pop strobe is shown while the flops are held in reset.
  assign kbd_read_n = ~((state == IDLE) & kbd_ready & rst_n);
  assign held_match = held_valid & (held_ext == ext_pend) & (held_code == byte_r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      byte_r       <= '0;
      ext_pend     <= 1'b0;
      brk_pend     <= 1'b0;
      held_valid   <= 1'b0;
      held_code    <= '0;
      held_ext     <= 1'b0;
      to_cnt       <= '0;
      evt_valid    <= 1'b0;
      evt_code     <= '0;
      evt_ext      <= 1'b0;
      evt_brk      <= 1'b0;
      evt_repeat   <= 1'b0;
      press_count  <= '0;
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_timeout  <= 1'b0;
      err_overflow <= err_overflow | kbd_overflow;
      case (state)
        IDLE: begin
          if (kbd_ready) begin
            byte_r <= kbd_data;
            to_cnt <= '0;
            state  <= DECODE;
          end else if (ext_pend | brk_pend) begin
            if (to_cnt == TO_LAST) begin
              ext_pend    <= 1'b0;
              brk_pend    <= 1'b0;
              err_timeout <= 1'b1;
              to_cnt      <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        DECODE: begin
          if (byte_r == PS2_EXT) begin
            ext_pend <= 1'b1;
            state    <= IDLE;
          end else if (byte_r == PS2_BRK) begin
            brk_pend <= 1'b1;
            state    <= IDLE;
          end else begin
            evt_code  <= byte_r;
            evt_ext   <= ext_pend;
            evt_brk   <= brk_pend;
            evt_valid <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
            state     <= EMIT;
            if (brk_pend) begin
              evt_repeat <= 1'b0;
              if (held_match) held_valid <= 1'b0;
            end else if (held_match) begin
              evt_repeat <= 1'b1;
            end else begin
              evt_repeat  <= 1'b0;
              press_count <= press_count + 1'b1;
              held_code   <= byte_r;
              held_ext    <= ext_pend;
              held_valid  <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: a byte-array FIFO model feeds the DUT and
// accepted events are logged for checking against hand-computed values.
module tb_ps2_kbd_ctrl;

  localparam int PT = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic       kbd_overflow = 1'b0;
  logic       kbd_read_n;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_brk;
  logic       evt_repeat;
  logic [7:0] press_count;
  logic       err_overflow;
  logic       err_timeout;

  ps2_kbd_ctrl #(.PREFIX_TIMEOUT(PT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kbd_ready    (kbd_ready),
    .kbd_data     (kbd_data),
    .kbd_overflow (kbd_overflow),
    .kbd_read_n   (kbd_read_n),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_ext      (evt_ext),
    .evt_brk      (evt_brk),
    .evt_repeat   (evt_repeat),
    .press_count  (press_count),
    .err_overflow (err_overflow),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_mem [0:31];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign kbd_ready = (wr_ptr != rd_ptr);
  assign kbd_data  = fifo_mem[rd_ptr[4:0]];

  int         cyc  = 0;
  int         ev_n = 0;
  int         to_n = 0;
  int         vcyc = 0;
  logic [7:0] ev_code [0:31];
  logic       ev_ext  [0:31];
  logic       ev_brk  [0:31];
  logic       ev_rep  [0:31];
  int         ev_cyc  [0:31];
  int         pop_cyc [0:31];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!kbd_read_n) begin
      pop_cyc[rd_ptr[4:0]] <= cyc;
      rd_ptr <= rd_ptr + 1;
    end
    if (evt_valid) vcyc <= vcyc + 1;
    if (evt_valid && evt_ready) begin
      ev_code[ev_n[4:0]] <= evt_code;
      ev_ext[ev_n[4:0]]  <= evt_ext;
      ev_brk[ev_n[4:0]]  <= evt_brk;
      ev_rep[ev_n[4:0]]  <= evt_repeat;
      ev_cyc[ev_n[4:0]]  <= cyc;
      ev_n <= ev_n + 1;
    end
    if (err_timeout) to_n <= to_n + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[4:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_ev(input string tag, input int i, input logic [7:0] code,
                        input logic ext, input logic brk, input logic rep);
    chk({tag, "_code"}, {24'h0, ev_code[i]}, {24'h0, code});
    chk({tag, "_ext"},  {31'h0, ev_ext[i]},  {31'h0, ext});
    chk({tag, "_brk"},  {31'h0, ev_brk[i]},  {31'h0, brk});
    chk({tag, "_rep"},  {31'h0, ev_rep[i]},  {31'h0, rep});
  endtask

  int base;
  int bad;

  initial begin
    for (int i = 0; i < 32; i++) fifo_mem[i] = 8'h00;

    // reset values
    cycles(3);
    chk("rst_read_n",  {31'h0, kbd_read_n},   32'h1);
    chk("rst_valid",   {31'h0, evt_valid},    32'h0);
    chk("rst_code",    {24'h0, evt_code},     32'h0);
    chk("rst_flags",   {29'h0, evt_ext, evt_brk, evt_repeat}, 32'h0);
    chk("rst_count",   {24'h0, press_count},  32'h0);
    chk("rst_errs",    {30'h0, err_overflow, err_timeout}, 32'h0);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    cycles(2);

    // single make, latency pop -> valid = 2
    push(8'h1C);
    cycles(8);
    chk("t1_evn", ev_n, 1);
    chk_ev("t1", 0, 8'h1C, 1'b0, 1'b0, 1'b0);
    chk("t1_count", {24'h0, press_count}, 32'd1);
    chk("t1_latency", ev_cyc[0] - pop_cyc[0], 2);

    // break of held key, then the same make is fresh again
    push(8'hF0); push(8'h1C);
    cycles(10);
    chk_ev("t2_brk", 1, 8'h1C, 1'b0, 1'b1, 1'b0);
    chk("t2_count", {24'h0, press_count}, 32'd1);
    push(8'h1C);
    cycles(8);
    chk_ev("t2_remake", 2, 8'h1C, 1'b0, 1'b0, 1'b0);
    chk("t2_count2", {24'h0, press_count}, 32'd2);

    // extended make / extended break, exactly 5 pops
    base = rd_ptr;
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    cycles(20);
    chk("t3_pops", rd_ptr - base, 5);
    chk("t3_evn", ev_n, 5);
    chk_ev("t3_make", 3, 8'h75, 1'b1, 1'b0, 1'b0);
    chk_ev("t3_brk",  4, 8'h75, 1'b1, 1'b1, 1'b0);
    chk("t3_count", {24'h0, press_count}, 32'd3);

    // typematic repeats; E0 1C differs from held 1C
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C); push(8'h1C);
    push(8'hE0); push(8'h1C);
    cycles(40);
    chk("t4_evn", ev_n, 11);
    chk("t4_reps", {27'h0, ev_rep[5], ev_rep[6], ev_rep[7], ev_rep[8], ev_rep[9]}, 32'b01100);
    chk("t4_brk8", {31'h0, ev_brk[8]}, 32'h1);
    chk_ev("t4_ext", 10, 8'h1C, 1'b1, 1'b0, 1'b0);
    chk("t4_count", {24'h0, press_count}, 32'd6);
    chk("valid_pulse", vcyc, ev_n);

    // prefix timeout discards F0
    push(8'hF0);
    cycles(22);
    chk("t5_to_n", to_n, 1);
    push(8'h1C);
    cycles(8);
    chk_ev("t5_after", 11, 8'h1C, 1'b0, 1'b0, 1'b0);
    chk("t5_count", {24'h0, press_count}, 32'd7);

    // pop coinciding with the timeout cycle wins
    push(8'hF0);
    cycles(17);
    push(8'h1C);
    cycles(8);
    chk("t5b_to_n", to_n, 1);
    chk_ev("t5b_brk", 12, 8'h1C, 1'b0, 1'b1, 1'b0);

    // sticky overflow
    kbd_overflow = 1'b1;
    cycles(1);
    kbd_overflow = 1'b0;
    chk("ovf_set", {31'h0, err_overflow}, 32'h1);
    cycles(3);
    chk("ovf_sticky", {31'h0, err_overflow}, 32'h1);

    // backpressure, then reset during EMIT
    evt_ready = 1'b0;
    base = rd_ptr;
    push(8'h2A); push(8'h2B); push(8'h2C);
    cycles(4);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (kbd_read_n !== 1'b1 || evt_valid !== 1'b1 || evt_code !== 8'h2A) bad++;
      @(negedge clk);
    end
    chk("bp_stable", bad, 0);
    chk("bp_pops", rd_ptr - base, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'h0, evt_valid}, 32'h0);
    chk("ar_read_n", {31'h0, kbd_read_n}, 32'h1);
    chk("ar_code", {24'h0, evt_code}, 32'h0);
    chk("ar_count", {24'h0, press_count}, 32'h0);
    chk("ar_ovf", {31'h0, err_overflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    cycles(12);
    chk("post_rst_pops", rd_ptr - base, 3);
    chk("post_rst_evn", ev_n, 15);
    chk_ev("post_rst_a", 13, 8'h2B, 1'b0, 1'b0, 1'b0);
    chk_ev("post_rst_b", 14, 8'h2C, 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", {24'h0, press_count}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
